// File: rtl/fifo_read_arbiter_if.sv
// Read-side pop bus shared between the FIFO read arbiter and its requesters.
// The master modport belongs to the arbiter, the slave modport to the consumer/FIFO side.
interface fifo_read_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0] req;
  logic            rempty;
  logic            ralmost_empty;
  logic            rinc;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] rvalid;
  logic            busy;

  modport master (
    input  req, rempty, ralmost_empty,
    output rinc, grant, rvalid, busy
  );

  modport slave (
    output req, rempty, ralmost_empty,
    input  rinc, grant, rvalid, busy
  );
endinterface

// File: rtl/fifo_read_arbiter.sv
// Burst-based round-robin arbiter sharing one FIFO pop port among NREQ requesters.
// Define FIFO_RD_ARB_PRIORITY_EN to replace round-robin with fixed lowest-index priority.
module fifo_read_arbiter #(
   parameter int NREQ      = 4,
   parameter int BURST_MAX = 4
) (
   input  logic                clk,
   input  logic                rst,
   fifo_read_arbiter_if.master bus
);

   localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNTW = $clog2(BURST_MAX + 1);
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(BURST_MAX - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [IDXW-1:0] winner;
   logic            pop;

`ifdef FIFO_RD_ARB_PRIORITY_EN
   function automatic logic [IDXW-1:0] pick(input logic [NREQ-1:0] r);
      logic [IDXW-1:0] idx;
      idx = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (r[i]) idx = IDXW'(i);
      end
      return idx;
   endfunction

   assign winner = pick(bus.req);
`else
   logic [IDXW-1:0] last_q, last_d;

   // Scan last+NREQ down to last+1 so the earliest position in round-robin order wins.
   function automatic logic [IDXW-1:0] pick(input logic [NREQ-1:0] r,
                                            input logic [IDXW-1:0] l);
      logic [IDXW-1:0] idx;
      logic [IDXW-1:0] j;
      idx = '0;
      for (int k = NREQ; k >= 1; k--) begin
         j = IDXW'((int'(l) + k) % NREQ);
         if (r[j]) idx = j;
      end
      return idx;
   endfunction

   function automatic logic [IDXW-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
      logic [IDXW-1:0] idx;
      idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (oh[i]) idx = IDXW'(i);
      end
      return idx;
   endfunction

   assign winner = pick(bus.req, last_q);
`endif

   // Pops are gated by rempty even while the grant is still registered high.
   assign pop = (|(grant_q & bus.req)) & ~bus.rempty;

   assign bus.rinc   = pop;
   assign bus.grant  = grant_q;
   assign bus.rvalid = grant_q & {NREQ{pop}};
   assign bus.busy   = (state_q == BURST);

   // NOTE: every next-state variable gets a default first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      cnt_d   = cnt_q;
`ifndef FIFO_RD_ARB_PRIORITY_EN
      last_d  = last_q;
`endif
      case (state_q)
         IDLE: begin
            grant_d = '0;
            cnt_d   = '0;
            if (|bus.req && !bus.rempty) begin
               grant_d[winner] = 1'b1;
               state_d         = BURST;
            end
         end
         BURST: begin
            // No pop means the owner dropped req or the FIFO is empty: leave either way.
            if (!pop || cnt_q == CNT_LAST || bus.ralmost_empty) begin
               state_d = IDLE;
               grant_d = '0;
               cnt_d   = '0;
`ifndef FIFO_RD_ARB_PRIORITY_EN
               last_d  = onehot_to_idx(grant_q);
`endif
            end else begin
               cnt_d = cnt_q + CNTW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // NOTE: registers update with non-blocking assignments so all state moves on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         cnt_q   <= '0;
`ifndef FIFO_RD_ARB_PRIORITY_EN
         last_q  <= IDXW'(NREQ - 1);
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
`ifndef FIFO_RD_ARB_PRIORITY_EN
         last_q  <= last_d;
`endif
      end
   end

endmodule
